sync_dp_mem: RTL and testbench

//   Synchronous simple-dual-port RAM: one write port, one read port, one clock.

---
 rtl/sync_dp_mem.sv | 157 +++++++++++++++
 tb/tb_sync_dp_mem.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_dp_mem.sv
// sync_dp_mem: simple-dual-port synchronous RAM with per-byte write enables,
// a 1- or 2-stage registered read pipeline with a valid strobe, a selectable
// read-during-write policy and an optional zero-fill walk after reset.
module sync_dp_mem #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WrEn,
  input  logic [ADDR_WIDTH-1:0]   WrAddr,
  input  logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH/8-1:0] WrBe,
  input  logic                    RdEn,
  input  logic [ADDR_WIDTH-1:0]   RdAddr,
  output logic [DATA_WIDTH-1:0]   RdData,
  output logic                    RdValid,
  output logic                    InitBusy
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_badLatency
      $error("sync_dp_mem: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_badWidth
      $error("sync_dp_mem: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ADDR_WIDTH-1:0]   r_clrCnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   w_rdWord;
  logic [DATA_WIDTH-1:0]   r_s1Data;
  logic                    r_s1Valid;
  logic                    w_running;
  logic                    w_clearing;
  logic                    w_wrAccept;
  logic                    w_rdAccept;

  // Reset has priority over everything: no clear step, write or read is taken on a reset edge.
  assign w_running  = (r_state == ST_RUN) && !rst;
  assign w_clearing = (r_state == ST_CLEAR) && !rst;
  assign w_wrAccept = WrEn && w_running;
  assign w_rdAccept = RdEn && w_running;
  assign InitBusy   = (r_state == ST_CLEAR);

  // State register; reset lands in CLEAR only when the zero-fill walk is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Leave CLEAR on the cycle that zeroes the last address.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clrCnt == LAST_ADDR) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN:   w_nextState = ST_RUN;
      default:  w_nextState = ST_RUN;
    endcase
  end

  // Clear address counter; restarts from zero on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clrCnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clrCnt <= r_clrCnt + 1'b1;
    end
  end

  // Storage array: one write port shared by the clear walk and user byte-lane writes.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_clrCnt] <= '0;
    end else if (w_wrAccept) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (WrBe[b]) begin
          r_mem[WrAddr][8*b +: 8] <= WrData[8*b +: 8];
        end
      end
    end
  end

  // Word presented to the read pipeline, optionally forwarding same-address write lanes.
  always_comb begin
    w_rdWord = r_mem[RdAddr];
    if (RDW_MODE != 0 && w_wrAccept && (WrAddr == RdAddr)) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (WrBe[b]) begin
          w_rdWord[8*b +: 8] = WrData[8*b +: 8];
        end
      end
    end
  end

  // First read stage; data only moves on an accepted read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
    end else begin
      r_s1Valid <= w_rdAccept;
      if (w_rdAccept) begin
        r_s1Data <= w_rdWord;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_s2Data;
      logic                  r_s2Valid;

      // Second read stage, again holding its data between valid reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2Valid <= 1'b0;
          r_s2Data  <= '0;
        end else begin
          r_s2Valid <= r_s1Valid;
          if (r_s1Valid) begin
            r_s2Data <= r_s1Data;
          end
        end
      end

      assign RdData  = r_s2Data;
      assign RdValid = r_s2Valid;
    end else begin : g_lat1
      assign RdData  = r_s1Data;
      assign RdValid = r_s1Valid;
    end
  endgenerate

endmodule

// File: tb/tb_sync_dp_mem.sv
// tb_sync_dp_mem: drives two instances (latency 1 / old-data and latency 2 /
// new-data) with identical stimulus and compares each against a queue-based
// behavioural memory model every cycle, plus directed vectors and sequences.
module tb_sync_dp_mem;

  localparam int DEPTH = 1024;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    logic        wrEn;
    logic [9:0]  wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrBe;
    logic        rdEn;
    logic [9:0]  rdAddr;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn;
  logic [9:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrBe;
  logic        rdEn;
  logic [9:0]  rdAddr;
  logic [31:0] rdData0, rdData1;
  logic        rdValid0, rdValid1;
  logic        initBusy0, initBusy1;

  logic [31:0] mMem [DEPTH];
  rd_t         q0[$];
  rd_t         q1[$];
  bit          started;
  bit          mBusy;
  int          mClrIdx;
  int          mCyc;
  logic [31:0] mHold0, mHold1;
  int          checks;
  int          errors;

  vec_t        vecs[9];

  always #5 clk = ~clk;

  sync_dp_mem #(.READ_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .WrEn(wrEn), .WrAddr(wrAddr), .WrData(wrData), .WrBe(wrBe),
    .RdEn(rdEn), .RdAddr(rdAddr), .RdData(rdData0), .RdValid(rdValid0), .InitBusy(initBusy0)
  );

  sync_dp_mem #(.READ_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .WrEn(wrEn), .WrAddr(wrAddr), .WrData(wrData), .WrBe(wrBe),
    .RdEn(rdEn), .RdAddr(rdAddr), .RdData(rdData1), .RdValid(rdValid1), .InitBusy(initBusy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) begin
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs currently applied.
  task automatic modelEdge();
    logic [31:0] oldWord;
    logic [31:0] newWord;
    if (rst) begin
      started = 1'b1;
      mBusy   = 1'b1;
      mClrIdx = 0;
      q0.delete();
      q1.delete();
      mHold0  = '0;
      mHold1  = '0;
    end else if (mBusy) begin
      mMem[mClrIdx] = '0;
      mClrIdx++;
      if (mClrIdx == DEPTH) mBusy = 1'b0;
    end else begin
      if (rdEn) begin
        oldWord = mMem[rdAddr];
        newWord = oldWord;
        if (wrEn && wrAddr == rdAddr) begin
          for (int b = 0; b < 4; b++) begin
            if (wrBe[b]) newWord[8*b +: 8] = wrData[8*b +: 8];
          end
        end
        q0.push_back('{due: mCyc + 1, data: oldWord});
        q1.push_back('{due: mCyc + 2, data: newWord});
      end
      if (wrEn) begin
        for (int b = 0; b < 4; b++) begin
          if (wrBe[b]) mMem[wrAddr][8*b +: 8] = wrData[8*b +: 8];
        end
      end
    end
    mCyc++;
  endtask

  task automatic checkOutput();
    bit exp0V;
    bit exp1V;
    exp0V = 1'b0;
    exp1V = 1'b0;
    if (q0.size() > 0 && q0[0].due == mCyc) begin
      exp0V  = 1'b1;
      mHold0 = q0[0].data;
      void'(q0.pop_front());
    end
    if (q1.size() > 0 && q1[0].due == mCyc) begin
      exp1V  = 1'b1;
      mHold1 = q1[0].data;
      void'(q1.pop_front());
    end
    if (started) begin
      chk("busy0", initBusy0, mBusy);
      chk("busy1", initBusy1, mBusy);
      chk("valid0", rdValid0, exp0V);
      chk("valid1", rdValid1, exp1V);
      chk("data0", rdData0, mHold0);
      chk("data1", rdData1, mHold1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic re, input logic [9:0] ra);
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    wrBe   = be;
    rdEn   = re;
    rdAddr = ra;
    tick();
  endtask

  task automatic waitClear(input string name);
    int n;
    n = 0;
    while (initBusy0 === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(name, n, 1024);
  endtask

  initial begin
    int cnt0;
    int cnt1;
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    mBusy   = 1'b0;
    mClrIdx = 0;
    mCyc    = 0;
    mHold0  = '0;
    mHold1  = '0;
    rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; wrBe = '0; rdEn = 1'b0; rdAddr = '0;

    vecs[0] = '{1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 10'h3FF, 32'h00000000, 32'h00000000};
    vecs[1] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0, 10'h000, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 10'h005, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 10'h005, 32'h11223344, 4'h5, 1'b0, 10'h000, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 10'h005, 32'hDE22BE44, 32'hDE22BE44};
    vecs[5] = '{1'b1, 10'h010, 32'hAAAAAAAA, 4'hF, 1'b0, 10'h000, 32'h0,        32'h0};
    vecs[6] = '{1'b1, 10'h010, 32'h55555555, 4'hF, 1'b1, 10'h010, 32'hAAAAAAAA, 32'h55555555};
    vecs[7] = '{1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 10'h010, 32'h55555555, 32'h55555555};
    vecs[8] = '{1'b1, 10'h3FF, 32'h12345678, 4'h0, 1'b1, 10'h3FF, 32'h00000000, 32'h00000000};

    // Reset for two cycles, then the zero-fill walk.
    tick();
    tick();
    chk("rstData0", rdData0, 32'h0);
    chk("rstBusy1", initBusy1, 1'b1);
    rst = 1'b0;
    waitClear("busyCycles1");

    // Directed vectors: latency, byte lanes, read-during-write, WrBe=0 no-op.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wrEn, vecs[i].wrAddr, vecs[i].wrData, vecs[i].wrBe,
                    vecs[i].rdEn, vecs[i].rdAddr);
      if (vecs[i].rdEn) begin
        chk("lat1Valid", rdValid0, 1'b1);
        chk("lat2Early", rdValid1, 1'b0);
        chk("lat1Data", rdData0, vecs[i].exp0);
      end
      applyStimulus(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
      if (vecs[i].rdEn) begin
        chk("lat2Valid", rdValid1, 1'b1);
        chk("lat2Data", rdData1, vecs[i].exp1);
        chk("lat1Pulse", rdValid0, 1'b0);
      end
    end

    // Reset mid-clear with requests during busy.
    applyStimulus(1'b1, 10'h020, 32'hCAFEF00D, 4'hF, 1'b0, 10'h0);
    rst = 1'b1;
    applyStimulus(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
    tick();
    rst = 1'b0;
    wrEn = 1'b1; wrAddr = 10'h020; wrData = 32'hFFFFFFFF; wrBe = 4'hF; rdEn = 1'b1; rdAddr = 10'h020;
    for (int i = 0; i < 500; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitClear("busyCycles2");
    applyStimulus(1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 10'h020);
    chk("clr020Valid", rdValid0, 1'b1);
    chk("clr020Data", rdData0, 32'h0);
    applyStimulus(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);

    // Random mixed traffic on a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom,
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    10'($urandom_range(0, 7)));
    end

    // Fill every address, then stream reads back-to-back.
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 10'(a), $urandom, 4'hF, 1'b0, 10'h0);
    end
    cnt0 = 0;
    cnt1 = 0;
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 10'(a));
      if (rdValid0) cnt0++;
      if (rdValid1) cnt1++;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
      if (rdValid0) cnt0++;
      if (rdValid1) cnt1++;
    end
    chk("streamCount0", cnt0, 1024);
    chk("streamCount1", cnt1, 1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
